// File: rtl/sevenseg_scan_capture.sv
// sevenseg_scan_capture: samples a multiplexed active-low seven-segment bus
// and reconstructs the hex value shown on each digit.
// Optional feature macro: SEVENSEG_HEX_EXT_EN (also recognise A..F glyphs).
module sevenseg_scan_capture #(
  parameter int unsigned DIGITS        = 4,
  parameter int unsigned STABLE_CYCLES = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DIGITS-1:0]     an,
  input  logic [0:6]            seg,
  output logic [4*DIGITS-1:0]   digits,
  output logic [DIGITS-1:0]     digit_valid,
  output logic [DIGITS-1:0]     digit_blank,
  output logic                  update,
  output logic [2:0]            update_idx,
  output logic                  pat_err,
  output logic                  multi_err
);

  localparam int unsigned CW  = 8;
  localparam int unsigned NZW = 4;
  localparam logic [CW-1:0] STABLE = CW'(STABLE_CYCLES);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_TRACK = 2'd1,
    ST_HOLD  = 2'd2
  } state_t;

  state_t               r_state;
  state_t               w_state_nxt;
  logic [DIGITS-1:0]    r_s_an;
  logic [0:6]           r_s_seg;
  logic [CW-1:0]        r_cnt;

  logic [4*DIGITS-1:0]  r_digits;
  logic [DIGITS-1:0]    r_valid;
  logic [DIGITS-1:0]    r_blank;
  logic                 r_update;
  logic [2:0]           r_update_idx;
  logic                 r_pat_err;
  logic                 r_multi_err;

  logic                 w_chg;
  logic                 w_an_idle;
  logic [NZW-1:0]       w_nzero;
  logic [2:0]           w_idx;
  logic                 w_eval;
  logic                 w_commit;
  logic                 w_multi;
  logic                 w_dec_ok;
  logic                 w_dec_blank;
  logic [3:0]           w_dec_val;

  // Incoming bus differs from the held sample: a new dwell starts at this edge
  assign w_chg     = (an != r_s_an) || (seg != r_s_seg);
  assign w_an_idle = &an;

  // Input sampling register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s_an  <= '1;
      r_s_seg <= '1;
    end else begin
      r_s_an  <= an;
      r_s_seg <= seg;
    end
  end

  // Stability counter: restarts at 1 on a new sample, saturates at STABLE
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (w_chg) begin
      r_cnt <= CW'(1);
    end else if (r_cnt < STABLE) begin
      r_cnt <= r_cnt + CW'(1);
    end
  end

  // Count active anodes and locate the selected digit
  always_comb begin
    w_nzero = '0;
    w_idx   = '0;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      if (!r_s_an[i]) begin
        w_nzero = w_nzero + NZW'(1);
        w_idx   = 3'(i);
      end
    end
  end

  // Glyph decoder for the held segment sample
  always_comb begin
    w_dec_ok    = 1'b1;
    w_dec_blank = 1'b0;
    w_dec_val   = 4'h0;
    case (r_s_seg)
      7'b1000000: w_dec_val = 4'h0;
      7'b1111001: w_dec_val = 4'h1;
      7'b0100100: w_dec_val = 4'h2;
      7'b0110000: w_dec_val = 4'h3;
      7'b0011001: w_dec_val = 4'h4;
      7'b0010010: w_dec_val = 4'h5;
      7'b0000010: w_dec_val = 4'h6;
      7'b1111000: w_dec_val = 4'h7;
      7'b0000000: w_dec_val = 4'h8;
      7'b0011000: w_dec_val = 4'h9;
`ifdef SEVENSEG_HEX_EXT_EN
      7'b0001000: w_dec_val = 4'hA;
      7'b0000011: w_dec_val = 4'hB;
      7'b1000110: w_dec_val = 4'hC;
      7'b0100001: w_dec_val = 4'hD;
      7'b0000110: w_dec_val = 4'hE;
      7'b0001110: w_dec_val = 4'hF;
`endif
      7'b1111111: begin
        w_dec_val   = 4'hF;
        w_dec_blank = 1'b1;
      end
      default:    w_dec_ok = 1'b0;
    endcase
  end

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // FSM next state: a bus change always wins, otherwise a stable dwell is held
  always_comb begin
    w_state_nxt = r_state;
    if (w_chg) begin
      w_state_nxt = w_an_idle ? ST_IDLE : ST_TRACK;
    end else if ((r_state == ST_TRACK) && (r_cnt == STABLE)) begin
      w_state_nxt = ST_HOLD;
    end
  end

  // FSM outputs: evaluate the dwell once, when it first becomes stable
  always_comb begin
    w_eval   = (r_state == ST_TRACK) && (r_cnt == STABLE);
    w_commit = w_eval && (w_nzero == NZW'(1));
    w_multi  = w_eval && (w_nzero > NZW'(1));
  end

  // Captured digit state and status flags
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_digits     <= '0;
      r_valid      <= '0;
      r_blank      <= '0;
      r_update     <= 1'b0;
      r_update_idx <= '0;
      r_pat_err    <= 1'b0;
      r_multi_err  <= 1'b0;
    end else begin
      r_update <= w_commit;
      if (w_commit) begin
        r_update_idx <= w_idx;
        if (!w_dec_ok) begin
          r_pat_err <= 1'b1;
        end
        for (int unsigned i = 0; i < DIGITS; i++) begin
          if (w_idx == 3'(i)) begin
            r_valid[i] <= w_dec_ok && !w_dec_blank;
            r_blank[i] <= w_dec_blank;
            if (w_dec_ok) begin
              r_digits[4*i +: 4] <= w_dec_val;
            end
          end
        end
      end
      if (w_multi) begin
        r_multi_err <= 1'b1;
      end
    end
  end

  assign digits      = r_digits;
  assign digit_valid = r_valid;
  assign digit_blank = r_blank;
  assign update      = r_update;
  assign update_idx  = r_update_idx;
  assign pat_err     = r_pat_err;
  assign multi_err   = r_multi_err;

endmodule

// File: tb/tb_sevenseg_scan_capture.sv
// Bench for sevenseg_scan_capture: directed table, corner sequences and a
// randomized phase, all checked every cycle against a dwell-length model.
module tb_sevenseg_scan_capture;

  localparam int unsigned DIGITS = 4;
  localparam int unsigned STABLE = 4;

`ifdef SEVENSEG_HEX_EXT_EN
  localparam bit EXT = 1'b1;
`else
  localparam bit EXT = 1'b0;
`endif
  localparam logic [3:0] D0 = EXT ? 4'hA : 4'h4;

  logic                 clk = 1'b0;
  logic                 rst;
  logic [DIGITS-1:0]    an;
  logic [0:6]           seg;
  logic [4*DIGITS-1:0]  digits;
  logic [DIGITS-1:0]    digit_valid;
  logic [DIGITS-1:0]    digit_blank;
  logic                 update;
  logic [2:0]           update_idx;
  logic                 pat_err;
  logic                 multi_err;

  int n_vec = 0;
  int n_err = 0;

  sevenseg_scan_capture #(.DIGITS(DIGITS), .STABLE_CYCLES(STABLE)) dut (
    .clk(clk), .rst(rst), .an(an), .seg(seg),
    .digits(digits), .digit_valid(digit_valid), .digit_blank(digit_blank),
    .update(update), .update_idx(update_idx),
    .pat_err(pat_err), .multi_err(multi_err)
  );

  always #5 clk = ~clk;

  // Segment glyphs (g..a, active low) for values 0..15; anything else = blank
  function automatic logic [6:0] seg_of(input int v);
    case (v)
      0:  return 7'b1000000;
      1:  return 7'b1111001;
      2:  return 7'b0100100;
      3:  return 7'b0110000;
      4:  return 7'b0011001;
      5:  return 7'b0010010;
      6:  return 7'b0000010;
      7:  return 7'b1111000;
      8:  return 7'b0000000;
      9:  return 7'b0011000;
      10: return 7'b0001000;
      11: return 7'b0000011;
      12: return 7'b1000110;
      13: return 7'b0100001;
      14: return 7'b0000110;
      15: return 7'b0001110;
      default: return 7'b1111111;
    endcase
  endfunction

  // Reference model: a dwell commits on the edge after it has lasted STABLE samples
  logic [3:0]  m_an;
  logic [6:0]  m_seg;
  int          m_run;
  logic [15:0] exp_digits;
  logic [3:0]  exp_valid, exp_blank;
  logic        exp_update, exp_pat, exp_multi;
  logic [2:0]  exp_idx;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_an = 4'hF; m_seg = 7'h7F; m_run = 0;
      exp_digits = '0; exp_valid = '0; exp_blank = '0;
      exp_update = 1'b0; exp_pat = 1'b0; exp_multi = 1'b0; exp_idx = '0;
    end else begin
      int nz, pos, lim;
      bit ok;
      exp_update = 1'b0;
      if (m_run == STABLE) begin
        nz = 0; pos = 0;
        for (int i = 0; i < 4; i++) if (!m_an[i]) begin nz++; pos = i; end
        if (nz >= 2) exp_multi = 1'b1;
        if (nz == 1) begin
          exp_update = 1'b1;
          exp_idx = 3'(pos);
          lim = EXT ? 16 : 10;
          ok = 1'b0;
          for (int v = 0; v < lim; v++) begin
            if (m_seg == seg_of(v)) begin
              ok = 1'b1;
              exp_digits[4*pos +: 4] = 4'(v);
              exp_valid[pos] = 1'b1;
              exp_blank[pos] = 1'b0;
            end
          end
          if (m_seg == 7'h7F) begin
            exp_digits[4*pos +: 4] = 4'hF;
            exp_valid[pos] = 1'b0;
            exp_blank[pos] = 1'b1;
          end else if (!ok) begin
            exp_valid[pos] = 1'b0;
            exp_blank[pos] = 1'b0;
            exp_pat = 1'b1;
          end
        end
      end
      if ({an, seg} != {m_an, m_seg}) begin
        m_an = an; m_seg = seg; m_run = 1;
      end else if (m_run < 1000000) begin
        m_run++;
      end
    end
  end

  task automatic chk(input string tag, input string f, input logic [31:0] act, input logic [31:0] expv);
    n_vec++;
    if (act !== expv) begin
      n_err++;
      $display("FAIL %s.%s: got %0h expected %0h at %0t", tag, f, act, expv, $time);
    end
  endtask

  task automatic check_all(input string tag);
    chk(tag, "digits", 32'(digits), 32'(exp_digits));
    chk(tag, "valid",  32'(digit_valid), 32'(exp_valid));
    chk(tag, "blank",  32'(digit_blank), 32'(exp_blank));
    chk(tag, "update", 32'(update), 32'(exp_update));
    chk(tag, "pat_err", 32'(pat_err), 32'(exp_pat));
    chk(tag, "multi_err", 32'(multi_err), 32'(exp_multi));
    if (exp_update) chk(tag, "update_idx", 32'(update_idx), 32'(exp_idx));
  endtask

  // Hold one bus value for n cycles, checking every cycle and counting pulses
  task automatic apply(input string tag, input logic [3:0] a, input logic [6:0] s,
                       input int n, output int ups);
    an = a; seg = s; ups = 0;
    repeat (n) begin
      @(negedge clk);
      check_all(tag);
      if (update) ups++;
    end
  endtask

  typedef struct {
    logic [3:0]  an;
    logic [6:0]  seg;
    int          n;
    int          ups;
    logic [15:0] dig;
    logic [3:0]  val;
    logic [3:0]  blk;
    logic        pe;
    logic        me;
  } vec_t;

  vec_t tbl [11];

  initial begin
    int ups, tot;
    logic [3:0] ra;
    logic [6:0] rs;
    int rsel;

    tbl[0]  = '{4'b1110, seg_of(5),  10, 1, 16'h0005, 4'b0001, 4'b0000, 1'b0, 1'b0};
    tbl[1]  = '{4'b0111, seg_of(1),   8, 1, 16'h1005, 4'b1001, 4'b0000, 1'b0, 1'b0};
    tbl[2]  = '{4'b1011, seg_of(2),   8, 1, 16'h1205, 4'b1101, 4'b0000, 1'b0, 1'b0};
    tbl[3]  = '{4'b1101, seg_of(3),   8, 1, 16'h1235, 4'b1111, 4'b0000, 1'b0, 1'b0};
    tbl[4]  = '{4'b1110, seg_of(4),   8, 1, 16'h1234, 4'b1111, 4'b0000, 1'b0, 1'b0};
    tbl[5]  = '{4'b1111, 7'h7F,       6, 0, 16'h1234, 4'b1111, 4'b0000, 1'b0, 1'b0};
    tbl[6]  = '{4'b1101, 7'h7F,       6, 1, 16'h12F4, 4'b1101, 4'b0010, 1'b0, 1'b0};
    tbl[7]  = '{4'b1110, seg_of(10),  6, 1, {12'h12F, D0}, {3'b110, EXT}, 4'b0010, !EXT, 1'b0};
    tbl[8]  = '{4'b1011, seg_of(7),   6, 1, {12'h17F, D0}, {3'b110, EXT}, 4'b0010, !EXT, 1'b0};
    tbl[9]  = '{4'b1100, seg_of(8),   6, 0, {12'h17F, D0}, {3'b110, EXT}, 4'b0010, !EXT, 1'b1};
    tbl[10] = '{4'b1111, 7'h7F,       6, 0, {12'h17F, D0}, {3'b110, EXT}, 4'b0010, !EXT, 1'b1};

    rst = 1'b1; an = 4'hF; seg = 7'h7F;
    repeat (2) @(negedge clk);
    chk("reset", "digits", 32'(digits), 32'h0);
    chk("reset", "valid", 32'(digit_valid), 32'h0);
    chk("reset", "update", 32'(update), 32'h0);
    chk("reset", "errs", 32'({pat_err, multi_err}), 32'h0);
    rst = 1'b0;

    // Directed table
    for (int k = 0; k < 11; k++) begin
      string t;
      t = $sformatf("tbl%0d", k);
      apply(t, tbl[k].an, tbl[k].seg, tbl[k].n, ups);
      chk(t, "ups", 32'(ups), 32'(tbl[k].ups));
      chk(t, "dig", 32'(digits), 32'(tbl[k].dig));
      chk(t, "val", 32'(digit_valid), 32'(tbl[k].val));
      chk(t, "blk", 32'(digit_blank), 32'(tbl[k].blk));
      chk(t, "pe", 32'(pat_err), 32'(tbl[k].pe));
      chk(t, "me", 32'(multi_err), 32'(tbl[k].me));
    end

    // Glitch: 3-cycle segment toggles never commit, the final blank hold does
    apply("pre_glitch", 4'b1101, seg_of(9), 6, ups);
    chk("pre_glitch", "nib1", 32'(digits[7:4]), 32'h9);
    tot = 0;
    for (int k = 0; k < 4; k++) begin
      apply("glitch", 4'b1101, (k % 2 == 0) ? seg_of(1) : seg_of(2), 3, ups);
      tot += ups;
    end
    chk("glitch", "ups", 32'(tot), 32'd0);
    apply("glitch_hold", 4'b1101, 7'h7F, 8, ups);
    chk("glitch_hold", "ups", 32'(ups), 32'd1);
    chk("glitch_hold", "nib1", 32'(digits[7:4]), 32'hF);
    chk("glitch_hold", "blank1", 32'(digit_blank[1]), 32'd1);
    chk("glitch_hold", "valid1", 32'(digit_valid[1]), 32'd0);

    // Segment change within one anode dwell recommits the same digit
    apply("recommit_a", 4'b1110, seg_of(1), 6, ups);
    chk("recommit_a", "ups", 32'(ups), 32'd1);
    apply("recommit_b", 4'b1110, seg_of(2), 6, ups);
    chk("recommit_b", "ups", 32'(ups), 32'd1);
    chk("recommit_b", "nib0", 32'(digits[3:0]), 32'h2);

    // Long dwell saturates without recommitting
    apply("saturate", 4'b1110, seg_of(3), 300, ups);
    chk("saturate", "ups", 32'(ups), 32'd1);

    // Reset mid-dwell, then a full latency from release
    apply("rst_pre", 4'b1011, seg_of(7), 2, ups);
    rst = 1'b1;
    #1;
    chk("rst_async", "digits", 32'(digits), 32'h0);
    chk("rst_async", "flags", 32'({digit_valid, digit_blank, update, pat_err, multi_err}), 32'h0);
    @(negedge clk);
    rst = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      check_all("rst_post");
      chk("rst_lat", "update", 32'(update), (k == 5) ? 32'd1 : 32'd0);
    end
    chk("rst_post", "nib2", 32'(digits[11:8]), 32'h7);

    // Randomized dwells against the model
    for (int k = 0; k < 300; k++) begin
      rsel = int'($urandom_range(0, 9));
      if (rsel < 6)      ra = 4'hF & ~(4'b0001 << (rsel % 4));
      else if (rsel < 8) ra = 4'hF;
      else               ra = 4'($urandom);
      rsel = int'($urandom_range(0, 19));
      if (rsel < 16)      rs = seg_of(rsel);
      else if (rsel < 18) rs = 7'h7F;
      else                rs = 7'($urandom);
      apply("random", ra, rs, int'($urandom_range(1, 8)), ups);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
